// File: rtl/parity_frame_checker.sv
// Serial frame deserialiser with per-frame even/odd parity check, abort detection
// and a saturating parity-error counter.
module parity_frame_checker #(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic                 in_bit,
    input  logic                 sof,
    input  logic                 odd_mode,
    input  logic                 clr_cnt,
    output logic                 busy,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic                 parity_err,
    output logic                 frame_abort,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                   IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  idx_r;
    logic              par_run_r;
    logic              odd_lat_r;
    logic [DATA_W-1:0] shreg_r;

    logic              par_beat_s;
    logic              par_err_s;

    // Error when the total count of ones disagrees with the latched parity sense.
    function automatic logic parity_error(input logic run, input logic pbit, input logic odd);
        return run ^ pbit ^ odd;
    endfunction

    assign par_beat_s = in_valid & ~sof & (state_r == PAR);
    assign par_err_s  = parity_error(par_run_r, in_bit, odd_lat_r);

    // Frame FSM: deserialise, check parity, flag aborts; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            par_run_r   <= 1'b0;
            odd_lat_r   <= 1'b0;
            shreg_r     <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            parity_err  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            frame_abort <= 1'b0;
            if (in_valid && sof) begin
                // A sof always starts a new frame; mid-frame it also drops the old one.
                frame_abort <= (state_r != IDLE);
                shreg_r     <= DATA_W'(in_bit);
                odd_lat_r   <= odd_mode;
                par_run_r   <= in_bit;
                busy        <= 1'b1;
                if (DATA_W == 1) begin
                    state_r <= PAR;
                    idx_r   <= '0;
                end else begin
                    state_r <= DATA;
                    idx_r   <= IDX_W'(1);
                end
            end else if (in_valid) begin
                case (state_r)
                    DATA: begin
                        shreg_r   <= shreg_r | (DATA_W'(in_bit) << idx_r);
                        par_run_r <= par_run_r ^ in_bit;
                        if (idx_r == LAST_IDX) begin
                            state_r <= PAR;
                            idx_r   <= '0;
                        end else begin
                            idx_r   <= idx_r + IDX_W'(1);
                        end
                    end
                    PAR: begin
                        out_valid  <= 1'b1;
                        out_data   <= shreg_r;
                        parity_err <= par_err_s;
                        state_r    <= IDLE;
                        idx_r      <= '0;
                        par_run_r  <= 1'b0;
                        busy       <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Saturating parity-error counter; a clear takes priority over an increment.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (par_beat_s && par_err_s && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end else begin
            err_cnt <= err_cnt;
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed plus randomized bench for parity_frame_checker, checked against a
// frame-level behavioural model.
module tb_parity_frame_checker;

    localparam int DW      = 8;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn, in_valid, in_bit, sof, odd_mode, clr_cnt;
    logic          busy, out_valid, parity_err, frame_abort;
    logic [DW-1:0] out_data;
    logic [CW-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: frame in progress, bits collected so far, held results.
    bit        m_in_frame;
    bit [31:0] m_bits;
    int        m_nbits;
    bit        m_odd;
    bit [31:0] m_data;
    bit        m_err;
    int        m_cnt;
    bit        e_ov, e_fa;

    int        sat_exp [4] = '{1, 2, 3, 3};

    parity_frame_checker #(.DATA_W(DW), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_bit(in_bit), .sof(sof),
        .odd_mode(odd_mode), .clr_cnt(clr_cnt), .busy(busy), .out_valid(out_valid),
        .out_data(out_data), .parity_err(parity_err), .frame_abort(frame_abort),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic step(input bit rst, input bit v, input bit b, input bit s, input bit o, input bit clr);
        int ones;
        rstn = ~rst; in_valid = v; in_bit = b; sof = s; odd_mode = o; clr_cnt = clr;
        e_ov = 1'b0; e_fa = 1'b0;
        if (rst) begin
            m_in_frame = 1'b0; m_nbits = 0; m_data = 0; m_err = 1'b0; m_cnt = 0;
        end else begin
            if (v && s) begin
                e_fa = m_in_frame;
                m_in_frame = 1'b1; m_bits = {31'd0, b}; m_nbits = 1; m_odd = o;
            end else if (v && m_in_frame) begin
                if (m_nbits < DW) begin
                    m_bits[m_nbits] = b;
                    m_nbits++;
                end else begin
                    ones   = $countones(m_bits[DW-1:0]) + int'(b);
                    m_err  = ((ones % 2) == 1) != m_odd;
                    m_data = m_bits;
                    e_ov   = 1'b1;
                    m_in_frame = 1'b0;
                    if (m_err && m_cnt < CNT_MAX) m_cnt++;
                end
            end
            if (clr) m_cnt = 0;
        end
        @(posedge clk); #1;
        chk("busy",        {31'd0, busy},        {31'd0, m_in_frame});
        chk("out_valid",   {31'd0, out_valid},   {31'd0, e_ov});
        chk("frame_abort", {31'd0, frame_abort}, {31'd0, e_fa});
        chk("out_data",    {24'd0, out_data},    m_data);
        chk("parity_err",  {31'd0, parity_err},  {31'd0, m_err});
        chk("err_cnt",     {30'd0, err_cnt},     m_cnt);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // Sends 'beats' beats of a frame (DW+1 = complete), with optional random gaps.
    task automatic send_frame(input bit [31:0] data, input bit pbit, input bit odd,
                              input int gap_max, input int beats, input bit clr_par);
        for (int i = 0; i < beats; i++) begin
            bit b = (i < DW) ? data[i] : pbit;
            bit o = (i == 0) ? odd : 1'($urandom_range(0, 1));
            step(1'b0, 1'b1, b, (i == 0), o, (i == DW) && clr_par);
            if (gap_max > 0 && i < beats - 1) idle($urandom_range(0, gap_max));
        end
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);

        // Even mode, clean and erroneous.
        send_frame(32'hA5, 1'b0, 1'b0, 0, DW + 1, 1'b0);
        chk("tp_even_data", {24'd0, out_data}, 32'hA5);
        chk("tp_even_err",  {31'd0, parity_err}, 32'd0);
        send_frame(32'hA5, 1'b1, 1'b0, 0, DW + 1, 1'b0);
        chk("tp_even_err1", {31'd0, parity_err}, 32'd1);
        chk("tp_even_cnt1", {30'd0, err_cnt}, 32'd1);

        // Odd mode.
        send_frame(32'h01, 1'b0, 1'b1, 0, DW + 1, 1'b0);
        chk("tp_odd_ok", {31'd0, parity_err}, 32'd0);
        send_frame(32'h03, 1'b0, 1'b1, 0, DW + 1, 1'b0);
        chk("tp_odd_err", {31'd0, parity_err}, 32'd1);

        // Abort with gaps, then a clean frame.
        send_frame(32'hFF, 1'b0, 1'b0, 0, 3, 1'b0);
        idle(2);
        send_frame(32'h3C, 1'b0, 1'b0, 0, DW + 1, 1'b0);
        chk("tp_abort_data", {24'd0, out_data}, 32'h3C);
        // Abort while waiting for the parity beat.
        send_frame(32'h11, 1'b0, 1'b0, 1, DW, 1'b0);
        send_frame(32'h5A, 1'b1, 1'b0, 1, DW + 1, 1'b0);

        // Saturation and clear-wins.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int f = 0; f < 4; f++) begin
            send_frame(32'h07, 1'b0, 1'b0, 0, DW + 1, 1'b0);
            chk("tp_sat_cnt", {30'd0, err_cnt}, sat_exp[f]);
        end
        send_frame(32'h07, 1'b0, 1'b0, 0, DW + 1, 1'b1);
        chk("tp_clr_cnt", {30'd0, err_cnt}, 32'd0);

        // Reset mid-frame, then a full frame.
        send_frame(32'h9E, 1'b0, 1'b0, 0, 5, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(32'hC3, 1'b1, 1'b1, 0, DW + 1, 1'b0);

        // Randomized frames with gaps, aborts and clears.
        for (int f = 0; f < 300; f++) begin
            int beats = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, DW)) : DW + 1;
            send_frame($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       2, beats, ($urandom_range(0, 15) == 0));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
